// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register for a 64-bit RISC-V core.
// Pairs the fetch PC with instruction memory read data, which returns one
// cycle after the address is presented. Stall, flush and reset are handled
// here, and a saturating count of inserted bubbles is kept.
module if_id_pipe_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [63:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [63:0] pc_plus4_out,
    output logic [15:0] bubble_count
);

    // PC of the fetch whose data arrives on instr_in this cycle
    logic [63:0] pc_d1;
    // Set when instr_in carries a fetch that has not been squashed
    logic        inflight_valid;

    // Values the ID-side registers load on a non-reset edge
    logic [63:0] pc_next;
    logic [31:0] instr_next;
    logic        valid_next;
    // This edge loads a bubble (valid_out=0) into the ID-side registers
    logic        bubble;

    // Select what the ID-side registers take on this edge; flush outranks stall.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pc_next    = pc_out;
        instr_next = instr_out;
        valid_next = valid_out;
        if (flush) begin
            pc_next    = '0;
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (!stall) begin
            pc_next    = pc_d1;
            valid_next = inflight_valid;
            instr_next = inflight_valid ? instr_in : NOP_INSTR;
        end
    end

    // A bubble is loaded on a flush, or on an advancing edge with nothing in flight.
    assign bubble = flush | (~stall & ~inflight_valid);

    // Track the fetch in flight so its PC lines up with the memory data.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_d1          <= '0;
            inflight_valid <= 1'b0;
        end else begin
            if (!stall) begin
                pc_d1 <= pc_in;
            end
            if (flush) begin
                inflight_valid <= 1'b0;
            end else if (!stall) begin
                inflight_valid <= 1'b1;
            end
        end
    end

    // ID-side registers: reset, then flush / hold / advance as chosen above.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_out    <= '0;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else begin
            pc_out    <= pc_next;
            instr_out <= instr_next;
            valid_out <= valid_next;
        end
    end

    // Saturating bubble counter; stall-hold edges never count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_count <= '0;
        end else if (bubble && (bubble_count != 16'hFFFF)) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end

    // Link value for JAL/JALR, wraps modulo 2^64.
    assign pc_plus4_out = pc_out + 64'd4;

endmodule
